// File: rtl/seg_check_pipe_pkg.sv
// Shared descriptor layout, page geometry and stage-B state encoding for seg_check_pipe.
package seg_check_pipe_pkg;

    // Descriptor cache bit positions
    localparam int unsigned DESC_BIT_G    = 55;
    localparam int unsigned DESC_BIT_DB   = 54;
    localparam int unsigned DESC_BIT_P    = 47;
    localparam int unsigned DESC_BIT_CODE = 43;
    localparam int unsigned DESC_BIT_EC   = 42;  // expand-down (data) / conforming (code)
    localparam int unsigned DESC_BIT_RW   = 41;  // writable (data) / readable (code)

    localparam int unsigned PAGE_SIZE = 4096;

    // Segment indices
    localparam int unsigned SEG_ES = 0;
    localparam int unsigned SEG_CS = 1;
    localparam int unsigned SEG_SS = 2;
    localparam int unsigned SEG_DS = 3;
    localparam int unsigned SEG_FS = 4;
    localparam int unsigned SEG_GS = 5;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StSplit0,
        StSplit1
    } stb_state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] limit;
        logic [31:0] upper;
        logic        present;
        logic        is_code;
        logic        expand_down;
        logic        readable;
        logic        writable;
    } desc_info_t;

endpackage

// File: rtl/seg_desc_decode.sv
// Combinational decode of a 64-bit descriptor cache entry into base, limits and type flags.
module seg_desc_decode
    import seg_check_pipe_pkg::*;
(
    input  logic [63:0] desc,
    output desc_info_t  info
);

    // Field extraction; readable/writable already folded for code vs data
    always_comb begin
        info.base        = {desc[63:56], desc[39:16]};
        info.limit       = desc[DESC_BIT_G] ? {desc[51:48], desc[15:0], 12'hFFF}
                                            : {12'd0, desc[51:48], desc[15:0]};
        info.upper       = {{16{desc[DESC_BIT_DB]}}, 16'hFFFF};
        info.present     = desc[DESC_BIT_P];
        info.is_code     = desc[DESC_BIT_CODE];
        info.expand_down = !desc[DESC_BIT_CODE] && desc[DESC_BIT_EC];
        info.readable    = !desc[DESC_BIT_CODE] || desc[DESC_BIT_RW];
        info.writable    = !desc[DESC_BIT_CODE] && desc[DESC_BIT_RW];
    end

    // S, DPL, accessed and AVL/L bits play no part in the check
    logic unused_desc;
    assign unused_desc = ^{desc[53:52], desc[46:44], desc[40]};

endmodule

// File: rtl/seg_check_pipe.sv
// Two-stage segment checker: stage A snapshots the request and descriptor, stage B checks it
// and emits one or two registered response beats (two when crossing a 4 KiB page).
module seg_check_pipe
    import seg_check_pipe_pkg::*;
#(
    parameter int unsigned NUM_SEG   = 6,
    parameter int unsigned STACK_SEG = SEG_SS,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [64*NUM_SEG-1:0]      seg_cache,
    input  logic [NUM_SEG-1:0]         seg_cache_valid,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [$clog2(NUM_SEG)-1:0] req_seg,
    input  logic [31:0]                req_offset,
    input  logic [LEN_W-1:0]           req_length,
    input  logic                       req_read,
    input  logic                       req_write,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_linear,
    output logic [LEN_W-1:0]           rsp_length,
    output logic                       rsp_last,
    output logic                       rsp_fault_gp,
    output logic                       rsp_fault_ss,
    output logic [TAG_W-1:0]           rsp_tag
);

    localparam int unsigned SEG_W = $clog2(NUM_SEG);

    // Stage A state
    logic             a_valid_q, a_valid_d;
    logic [31:0]      a_offset_q;
    logic [LEN_W-1:0] a_length_q;
    logic             a_read_q, a_write_q;
    logic [TAG_W-1:0] a_tag_q;
    logic [SEG_W-1:0] a_seg_q;
    logic [63:0]      a_desc_q;
    logic             a_dvalid_q;

    logic [63:0] sel_desc;
    logic        sel_dvalid;
    logic        a_capture, a_adv, b_free, b_load, b_beat1;

    // Stage B state
    stb_state_e       state_q, state_d;
    logic [31:0]      rsp_linear_q, b1_linear_q;
    logic [LEN_W-1:0] rsp_length_q, b1_length_q;
    logic             rsp_last_q, rsp_gp_q, rsp_ss_q;
    logic [TAG_W-1:0] rsp_tag_q;

    // Stage B check results
    desc_info_t       info;
    logic             overflow, too_short, kind_bad, fault, split, is_stack;
    logic [31:0]      left, linear;
    logic [12:0]      page_end, first_len13;
    logic [LEN_W-1:0] first_len, second_len;

    // Select the addressed descriptor; out-of-range indices read as an invalid cache
    always_comb begin
        sel_desc   = '0;
        sel_dvalid = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (req_seg == SEG_W'(i)) begin
                sel_desc   = seg_cache[64*i +: 64];
                sel_dvalid = seg_cache_valid[i];
            end
        end
    end

    assign req_ready = !a_valid_q || a_adv;
    assign a_capture = req_valid && req_ready && !flush;

    // Stage A occupancy: flush wins, then capture, then drain into stage B
    always_comb begin
        a_valid_d = a_valid_q;
        if (flush) begin
            a_valid_d = 1'b0;
        end else if (a_capture) begin
            a_valid_d = 1'b1;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end
    end

    // Stage A registers: request fields plus descriptor snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q  <= 1'b0;
            a_offset_q <= '0;
            a_length_q <= '0;
            a_read_q   <= 1'b0;
            a_write_q  <= 1'b0;
            a_tag_q    <= '0;
            a_seg_q    <= '0;
            a_desc_q   <= '0;
            a_dvalid_q <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            if (a_capture) begin
                a_offset_q <= req_offset;
                a_length_q <= req_length;
                a_read_q   <= req_read;
                a_write_q  <= req_write;
                a_tag_q    <= req_tag;
                a_seg_q    <= req_seg;
                a_desc_q   <= sel_desc;
                a_dvalid_q <= sel_dvalid;
            end
        end
    end

    seg_desc_decode u_decode (
        .desc (a_desc_q),
        .info (info)
    );

    // Limit, length and permission checks plus page-split geometry
    always_comb begin
        if (info.expand_down) begin
            overflow = (a_offset_q <= info.limit) || (a_offset_q > info.upper);
            left     = info.upper - a_offset_q;
        end else begin
            overflow = a_offset_q > info.limit;
            left     = info.limit - a_offset_q;
        end
        too_short   = ({1'b0, left} + 33'd1) < 33'(a_length_q);
        kind_bad    = (a_read_q && info.is_code && !info.readable) ||
                      (a_write_q && !info.writable);
        fault       = (a_read_q || a_write_q) &&
                      (!(info.present && a_dvalid_q) || overflow || too_short || kind_bad);
        is_stack    = (a_seg_q == SEG_W'(STACK_SEG));
        linear      = info.base + a_offset_q;
        page_end    = {1'b0, linear[11:0]} + 13'(a_length_q);
        split       = !fault && (page_end > 13'(PAGE_SIZE));
        first_len13 = 13'(PAGE_SIZE) - {1'b0, linear[11:0]};
        first_len   = LEN_W'(first_len13);
        second_len  = a_length_q - first_len;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (a_valid_q) state_d = split ? StSplit0 : StOne;
                end
                StOne, StSplit1: begin
                    if (rsp_ready) begin
                        if (a_valid_q) state_d = split ? StSplit0 : StOne;
                        else           state_d = StEmpty;
                    end
                end
                StSplit0: begin
                    if (rsp_ready) state_d = StSplit1;
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // FSM outputs: response valid and stage handoff strobes
    always_comb begin
        rsp_valid = (state_q != StEmpty);
        b_free    = (state_q == StEmpty) ||
                    (((state_q == StOne) || (state_q == StSplit1)) && rsp_ready);
        a_adv     = a_valid_q && b_free;
        b_load    = a_adv && !flush;
        b_beat1   = (state_q == StSplit0) && rsp_ready && !flush;
    end

    // Response registers: load first beat from stage A, or swap in the held second beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_linear_q <= '0;
            rsp_length_q <= '0;
            rsp_last_q   <= 1'b0;
            rsp_gp_q     <= 1'b0;
            rsp_ss_q     <= 1'b0;
            rsp_tag_q    <= '0;
            b1_linear_q  <= '0;
            b1_length_q  <= '0;
        end else if (b_load) begin
            rsp_linear_q <= linear;
            rsp_length_q <= split ? first_len : a_length_q;
            rsp_last_q   <= !split;
            rsp_gp_q     <= fault && !is_stack;
            rsp_ss_q     <= fault && is_stack;
            rsp_tag_q    <= a_tag_q;
            b1_linear_q  <= {linear[31:12] + 20'd1, 12'd0};
            b1_length_q  <= second_len;
        end else if (b_beat1) begin
            rsp_linear_q <= b1_linear_q;
            rsp_length_q <= b1_length_q;
            rsp_last_q   <= 1'b1;
        end
    end

    assign rsp_linear   = rsp_linear_q;
    assign rsp_length   = rsp_length_q;
    assign rsp_last     = rsp_last_q;
    assign rsp_fault_gp = rsp_gp_q;
    assign rsp_fault_ss = rsp_ss_q;
    assign rsp_tag      = rsp_tag_q;

endmodule

// File: doc/seg_check_pipe.md
# seg_check_pipe

Pipelined, parametrised segment checker and linear-address generator for the ao486 read/write path. Accepts one offset-based access per cycle over a valid/ready handshake, snapshots the selected descriptor cache, applies present/type/limit/expand-down/length checks, and returns a linear address with #GP/#SS fault classification. Unlike the single-cycle combinational checker it replaces, it is registered, flushable, supports a configurable segment count, and splits accesses crossing a 4 KiB linear page into two response beats for the TLB.

## Interface
- NUM_SEG, 6: number of segment descriptor caches; index order ES,CS,SS,DS,FS,GS,…
- STACK_SEG, 2: segment index whose faults are reported as #SS.
- LEN_W, 4: width of access length in bytes; max length 2^LEN_W-1.
- TAG_W, 4: width of opaque request tag.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill, takes priority over all traffic.
- seg_cache  in  64*NUM_SEG  descriptor caches, entry i at [64*i+63:64*i].
- seg_cache_valid  in  NUM_SEG  per-segment cache valid.
- req_valid / req_ready  in / out  1  request handshake.
- req_seg  in  $clog2(NUM_SEG)  segment index.
- req_offset  in  32  effective address.
- req_length  in  LEN_W  bytes, 1..max.
- req_read, req_write  in  1 each  access kind (both = RMW).
- req_tag  in  TAG_W  returned unchanged.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_linear  out  32  linear address of this beat.
- rsp_length  out  LEN_W  bytes in this beat.
- rsp_last  out  1  final beat of the access.
- rsp_fault_gp, rsp_fault_ss  out  1 each  fault classification.
- rsp_tag  out  TAG_W.

## Operation
- Stage A (capture): on req_valid&&req_ready register offset, length, kind, tag, seg index, and a snapshot of the selected descriptor + valid bit. Later seg_cache changes do not affect in-flight requests.
- Stage B (check), from stage-A registers: limit = G ? {d[51:48],d[15:0],12'hFFF} : {12'd0,d[51:48],d[15:0]}; base = {d[63:56],d[39:16]}; upper = {{16{d[54]}},16'hFFFF}.
- Normal (code, or data not expand-down): overflow if offset > limit; left = limit-offset. Expand-down data: overflow if offset <= limit or offset > upper; left = upper-offset.
- Fault = ~(P && valid) || overflow || (left+1 < length, computed 33-bit, no wrap) || (read && code && !readable) || (write && (code || !writable)). Request with neither read nor write: no fault.
- Fault reported as rsp_fault_ss if seg == STACK_SEG, else rsp_fault_gp; single beat, rsp_last=1, rsp_length=req_length, rsp_linear=base+offset.
- linear = base+offset mod 2^32. Non-faulting and linear[11:0]+length > 4096: two beats — beat0 length 4096-linear[11:0], rsp_last=0; beat1 linear {linear[31:12]+1,12'd0} (wraps to 0 past 0xFFFFF000), length remainder, rsp_last=1. Otherwise one beat.
- Stage-B FSM: EMPTY → ONE (single) or SPLIT0 on stage-A advance; SPLIT0 → SPLIT1 on rsp_ready; ONE/SPLIT1 → EMPTY on rsp_ready, or reload from stage A same cycle.
- req_ready = stage A empty, or stage A advancing into stage B this cycle.
- flush: both stages and FSM to EMPTY next cycle; request presented with flush is dropped.

## Timing
- Reset: rsp_valid=0, req_ready=1, all rsp_* data 0, FSM EMPTY.
- Latency: accept at cycle N → rsp_valid at N+2 (no backpressure). Throughput 1 access/cycle for unsplit; split occupies stage B 2 cycles.
- rsp_* stable while rsp_valid&&!rsp_ready. Outputs registered; no combinational req→rsp path. req_ready depends on rsp_ready combinationally.
- Reset asserted mid-split: beat1 never issued.

## Structure
- Shared package: descriptor bit positions (DESC_BIT_G, DESC_BIT_P, type bits 43/42/41, D/B 54), page size constant, segment index constants.
- One sub-module: seg_desc_decode (combinational descriptor → base, effective limit, upper bound, type flags), instantiated once in stage B.

## Test plan
- DS flat (base 0, limit FFFFF, G=1, RW data), offset 0x1000, len 4 → one beat linear 0x1000, no fault, latency 2.
- DS base 0x10000, byte limit 0xFFFF, offset 0xFFFE, len 4 → rsp_fault_gp=1, single beat; same on SS (index 2) → rsp_fault_ss=1.
- Expand-down DS, limit 0x0FFF, B=0: offset 0x0FFF → fault; 0x1000 len 2 → ok; 0xFFFF len 2 → fault.
- Flat DS, offset 0x0FFE, len 8 → beat0 0x0FFE/len 2/last 0, beat1 0x1000/len 6/last 1; hold rsp_ready low 3 cycles between beats, data stable.
- Code segment non-readable, read → #GP; readable code, write → #GP; cache_valid=0 → #GP.
- Back-to-back 8 requests with random rsp_ready, flush mid-stream → no beats after flush, req_ready=1 next cycle, tags in order.
